// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sharing of one I2C register-write master.
// Optional WAIT_DONE watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*7-1:0] req_chip_addr,
  input  logic [NUM_REQ*8-1:0] req_reg_addr,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic                 m_start,
  output logic [6:0]           m_chip_addr,
  output logic [7:0]           m_reg_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  input  logic                 m_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] cur;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;
  logic          tmo;

  // Walk downward so the candidate nearest ptr+1 is written last.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == WAIT_DONE) begin
      cnt <= cnt + 16'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign tmo = (state == WAIT_DONE) &&
               (cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_REQ - 1);
      cur         <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      busy        <= 1'b0;
      m_start     <= 1'b0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_wdata     <= '0;
    end else begin
      m_start <= 1'b0;
      done    <= '0;
      err     <= '0;
      unique case (state)
        IDLE: begin
          if (found) begin
            gnt         <= ONE << win;
            cur         <= win;
            m_start     <= 1'b1;
            busy        <= 1'b1;
            m_chip_addr <= req_chip_addr[7*win +: 7];
            m_reg_addr  <= req_reg_addr[8*win +: 8];
            m_wdata     <= req_wdata[8*win +: 8];
            state       <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (m_done || tmo) begin
            done[cur] <= 1'b1;
            err[cur]  <= m_done ? m_err : 1'b1;
            gnt       <= '0;
            ptr       <= cur;
            state     <= RESP;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
